// File: rtl/ram_march_bist_if.sv
// Port bundle between the March C- BIST engine and its surroundings:
// the test request/status handshake plus the single-port RAM bus it drives.
interface ram_march_bist_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic          start;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    // The BIST engine: takes the test request and RAM read data, drives status and the RAM port.
    modport master (
        input  start, mem_dout,
        output busy, done, fail, fail_addr, fail_elem, mem_we, mem_addr, mem_din
    );

    // Test controller / RAM side.
    modport slave (
        output start, mem_dout,
        input  busy, done, fail, fail_addr, fail_elem, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/ram_march_bist.sv
// March C- built-in self-test for a single-port synchronous RAM with registered dout.
// Reports pass/fail plus the first failing address and march element (1..5).
module ram_march_bist #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input logic              clk,
    input logic              rst,
    ram_march_bist_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RW_WRITE,
        FINAL_CHK
    } state_t;

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    state_t        state;
    logic [2:0]    elem;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    // Read-compare pipeline: carries the expected background and (A,e) into the dout cycle.
    logic          chk_valid;
    logic          chk_bit;
    logic [AW-1:0] chk_addr;
    logic [2:0]    chk_elem;
    logic          mismatch;

    function automatic logic is_desc(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic [AW-1:0] first_addr(input logic [2:0] e);
        return is_desc(e) ? LAST : '0;
    endfunction

    function automatic logic [AW-1:0] last_addr(input logic [2:0] e);
        return is_desc(e) ? '0 : LAST;
    endfunction

    // Odd elements read P0 and write P1; even elements the reverse.
    assign mismatch = chk_valid && (bus.mem_dout != {DW{chk_bit}});

    // NOTE: every state register uses non-blocking assignment so all of them
    // update together from the values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= '0;
            addr      <= '0;
            we        <= 1'b0;
            din       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            chk_valid <= 1'b0;
            chk_bit   <= 1'b0;
            chk_addr  <= '0;
            chk_elem  <= '0;
        end else begin
            chk_valid <= 1'b0;

            if (mismatch && !fail) begin
                fail      <= 1'b1;
                fail_addr <= chk_addr;
                fail_elem <= chk_elem;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= WRITE;
                        elem      <= 3'd0;
                        addr      <= '0;
                        we        <= 1'b1;
                        din       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                    end
                end

                WRITE: begin
                    if (addr == LAST) begin
                        state <= READ;
                        elem  <= 3'd1;
                        addr  <= first_addr(3'd1);
                        we    <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end

                READ: begin
                    chk_valid <= 1'b1;
                    chk_bit   <= ~elem[0];
                    chk_addr  <= addr;
                    chk_elem  <= elem;
                    if (elem == 3'd5) begin
                        if (addr == LAST) begin
                            state <= FINAL_CHK;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end else begin
                        // Write back to the same address while its read is being compared.
                        state <= RW_WRITE;
                        we    <= 1'b1;
                        din   <= {DW{elem[0]}};
                    end
                end

                RW_WRITE: begin
                    state <= READ;
                    we    <= 1'b0;
                    if (addr == last_addr(elem)) begin
                        elem <= elem + 3'd1;
                        addr <= first_addr(elem + 3'd1);
                    end else if (is_desc(elem)) begin
                        addr <= addr - 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end

                FINAL_CHK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.fail      = fail;
    assign bus.fail_addr = fail_addr;
    assign bus.fail_elem = fail_elem;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_din   = din;
endmodule

// File: tb/tb_ram_march_bist.sv
// Scoreboard bench for ram_march_bist: an AW=3 instance with a fault-injectable RAM model
// and an AW=2 instance whose full access trace is compared against the March C- order.
module tb_ram_march_bist;
    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int N   = 8;
    localparam int AW2 = 2;
    localparam int N2  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_march_bist_if #(.DW(DW), .AW(AW))  bus ();
    ram_march_bist_if #(.DW(DW), .AW(AW2)) bus2 ();

    ram_march_bist #(.DW(DW), .AW(AW))  dut  (.clk(clk), .rst(rst), .bus(bus));
    ram_march_bist #(.DW(DW), .AW(AW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // RAM models with registered dout; faults are switched by the stimulus.
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem2 [N2];
    logic          fault_sa;
    logic          fault_alias;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem1[bus.mem_addr] <= bus.mem_din;
            if (fault_alias && bus.mem_addr == 3'd2) mem1[3] <= bus.mem_din;
        end
        bus.mem_dout <= mem1[bus.mem_addr] |
                        ((fault_sa && bus.mem_addr == 3'd5) ? 8'h01 : 8'h00);
    end

    always @(posedge clk) begin
        if (bus2.mem_we) mem2[bus2.mem_addr] <= bus2.mem_din;
        bus2.mem_dout <= mem2[bus2.mem_addr];
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Expected outcome of one run, compared when busy falls.
    typedef struct {
        logic          done;
        logic          fail;
        logic [AW-1:0] faddr;
        logic [2:0]    felem;
        int            bc;
        int            wr;
        int            rd;
    } rec_t;

    rec_t exp_q[$];

    function automatic rec_t mk(input logic d, input logic f, input logic [AW-1:0] a,
                                input logic [2:0] e, input int bc, input int wr, input int rd);
        rec_t r;
        r.done = d; r.fail = f; r.faddr = a; r.felem = e;
        r.bc = bc; r.wr = wr; r.rd = rd;
        return r;
    endfunction

    // Run monitor: counts busy, write and non-write busy cycles, then scores at busy fall.
    logic busy_q = 1'b0;
    int   bc, wr, rd;
    int   run_idx = 0;

    always @(negedge clk) begin
        rec_t r;
        if (bus.busy && !busy_q) begin
            bc = 0; wr = 0; rd = 0;
        end
        if (bus.busy) bc++;
        if (bus.mem_we) wr++;
        if (bus.busy && !bus.mem_we) rd++;
        if (!bus.busy && busy_q) begin
            check($sformatf("run%0d_record_available", run_idx), 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check($sformatf("run%0d_done", run_idx),      bus.done,      r.done);
                check($sformatf("run%0d_fail", run_idx),      bus.fail,      r.fail);
                check($sformatf("run%0d_fail_addr", run_idx), bus.fail_addr, r.faddr);
                check($sformatf("run%0d_fail_elem", run_idx), bus.fail_elem, r.felem);
                check($sformatf("run%0d_busy_cycles", run_idx), bc, r.bc);
                check($sformatf("run%0d_write_cycles", run_idx), wr, r.wr);
                check($sformatf("run%0d_nonwrite_busy", run_idx), rd, r.rd);
                check($sformatf("run%0d_we_at_end", run_idx), bus.mem_we, 1'b0);
            end
            run_idx++;
        end
        busy_q = bus.busy;
    end

    // Access trace scoreboard for the AW=2 instance.
    typedef struct packed {
        logic           we;
        logic [AW2-1:0] addr;
        logic [DW-1:0]  din;
    } acc_t;

    acc_t tr_q[$];
    int   tr_idx = 0;

    always @(negedge clk) begin
        acc_t e;
        if (bus2.busy && tr_q.size() > 0) begin
            e = tr_q.pop_front();
            check($sformatf("trace[%0d]", tr_idx),
                  {bus2.mem_we, bus2.mem_addr, (bus2.mem_we ? bus2.mem_din : 8'h00)}, e);
            tr_idx++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(name, bus.busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // March C- element table: direction, read?, write?, write background.
        int            desc_t [6] = '{0, 0, 0, 1, 1, 0};
        int            has_rd [6] = '{0, 1, 1, 1, 1, 1};
        int            has_wr [6] = '{1, 1, 1, 1, 1, 0};
        logic [DW-1:0] wpat   [6] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
        int            k;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus2.start  = 1'b0;
        fault_sa    = 1'b0;
        fault_alias = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",      bus.busy,      1'b0);
        check("rst_done",      bus.done,      1'b0);
        check("rst_fail",      bus.fail,      1'b0);
        check("rst_fail_addr", bus.fail_addr, 3'd0);
        check("rst_fail_elem", bus.fail_elem, 3'd0);
        check("rst_mem_we",    bus.mem_we,    1'b0);
        check("rst_mem_addr",  bus.mem_addr,  3'd0);
        check("rst_mem_din",   bus.mem_din,   8'h00);
        rst = 1'b0;

        // AW=2 access order: 10*N2 = 40 entries.
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N2; i++) begin
                logic [AW2-1:0] a;
                a = AW2'(desc_t[e] != 0 ? N2 - 1 - i : i);
                if (has_rd[e] != 0) tr_q.push_back('{we: 1'b0, addr: a, din: 8'h00});
                if (has_wr[e] != 0) tr_q.push_back('{we: 1'b1, addr: a, din: wpat[e]});
            end
        end
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        k = 0;
        while (bus2.busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("aw2_terminates",    bus2.busy,      1'b0);
        check("aw2_done",          bus2.done,      1'b1);
        check("aw2_fail",          bus2.fail,      1'b0);
        check("aw2_trace_drained", tr_q.size(),    0);

        // Fault-free run with a second start at cycle 10 that must be ignored.
        exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 81, 40, 41));
        pulse_start();
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("run_pass_terminates");

        // Stuck-at-1 on bit 0 of address 5: first seen by E1 reading 0x01.
        fault_sa = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 3'd5, 3'd1, 81, 40, 41));
        pulse_start();
        wait_idle("run_sa_terminates");

        // Restart from done with fail set: status clears on accept.
        fault_sa = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 81, 40, 41));
        pulse_start();
        check("restart_busy",      bus.busy,      1'b1);
        check("restart_done_clr",  bus.done,      1'b0);
        check("restart_fail_clr",  bus.fail,      1'b0);
        check("restart_faddr_clr", bus.fail_addr, 3'd0);
        check("restart_felem_clr", bus.fail_elem, 3'd0);
        wait_idle("run_restart_terminates");

        // Writes to 2 also land in 3: E1 reads 0xFF at address 3.
        fault_alias = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 3'd3, 3'd1, 81, 40, 41));
        pulse_start();
        wait_idle("run_alias_terminates");
        fault_alias = 1'b0;

        // Reset after 20 busy cycles: 8 E0 writes then 6 read/write pairs.
        exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 3'd0, 20, 14, 6));
        pulse_start();
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   bus.busy,   1'b0);
        check("midrst_done",   bus.done,   1'b0);
        check("midrst_fail",   bus.fail,   1'b0);
        check("midrst_mem_we", bus.mem_we, 1'b0);

        // start together with rst: rst wins.
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy",   bus.busy,   1'b0);
        check("rst_start_mem_we", bus.mem_we, 1'b0);

        // Clean pass after the aborted run.
        exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 81, 40, 41));
        pulse_start();
        wait_idle("run_clean_terminates");

        @(negedge clk);
        check("records_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
